// File: rtl/core_pkg.sv
// Shared ALU op-class codes, flag bit positions and flag computation helpers.
// Used by flags_unit, flags_stack and setcc_logic.
package core_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_LOGIC,
    CLS_RSVD
  } op_class_e;

  function automatic op_class_e decode_op(input logic [2:0] op);
    op_class_e cls;
    case (op)
      OP_ADD:   cls = CLS_ADD;
      OP_SUB:   cls = CLS_SUB;
      OP_LOGIC: cls = CLS_LOGIC;
      default:  cls = CLS_RSVD;
    endcase
    return cls;
  endfunction

  function automatic flags_t compute_flags(input op_class_e cls,
                                           input logic [31:0] value,
                                           input logic carry,
                                           input logic a_msb,
                                           input logic b_msb);
    flags_t f;
    f         = '0;
    f[FLAG_N] = value[31];
    f[FLAG_Z] = (value == 32'd0);
    f[FLAG_C] = carry;
    case (cls)
      CLS_ADD: f[FLAG_V] = (a_msb == b_msb) && (value[31] != a_msb);
      CLS_SUB: f[FLAG_V] = (a_msb != b_msb) && (value[31] != a_msb);
      default: f[FLAG_V] = 1'b0;
    endcase
    return f;
  endfunction

  // Only the bits selected by mask take the new value.
  function automatic flags_t merge_flags(input flags_t old_flags,
                                         input flags_t new_flags,
                                         input logic [3:0] mask);
    return (old_flags & ~mask) | (new_flags & mask);
  endfunction

endpackage

// File: rtl/flags_stack.sv
// LIFO of saved flag words: push, pop, push+pop swap, with occupancy counter.
// Storage is not reset; only the occupancy counter is.
module flags_stack
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [3:0]               wdata,
  output logic [3:0]               top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  flags_t      mem [DEPTH];
  logic [AW:0] count_reg;
  logic [AW:0] top_ptr;
  logic        full;
  logic        empty;
  logic        do_push;
  logic        do_pop;
  logic        do_swap;

  assign full    = (count_reg == CNT_MAX);
  assign empty   = (count_reg == '0);
  assign top_ptr = count_reg - CNT_ONE;

  // A swap needs an existing top entry; against an empty stack it is a failed pop.
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign do_swap = push && pop && !empty;
  assign err     = (push && !pop && full) || (pop && empty);

  assign top   = mem[top_ptr[AW-1:0]];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count_reg[AW-1:0]] <= wdata;
    end else if (do_swap) begin
      mem[top_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + CNT_ONE;
    end else if (do_pop) begin
      count_reg <= count_reg - CNT_ONE;
    end
  end

endmodule

// File: rtl/flags_unit.sv
// Condition-flag register {N,Z,C,V} with masked ALU updates and an optional
// save/restore stack, included only when FLAGS_UNIT_STACK_EN is defined.
module flags_unit
  import core_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [2:0]  res_op,
  input  logic [31:0] res_value,
  input  logic        res_carry,
  input  logic        res_a_msb,
  input  logic        res_b_msb,
  input  logic [3:0]  update_mask,
  input  logic        push,
  input  logic        pop,
  output logic [3:0]  current_flags,
  output logic        stack_full,
  output logic        stack_empty,
  output logic        err_sticky
);

  flags_t    flags_reg;
  flags_t    flags_next;
  flags_t    alu_flags;
  flags_t    stack_top;
  op_class_e op_class;
  logic      err_reg;
  logic      accept;
  logic      op_ok;
  logic      stack_load;
  logic      stack_err;

`ifdef FLAGS_UNIT_STACK_EN
  localparam int CW = $clog2(STACK_DEPTH) + 1;

  logic [CW-1:0] occupancy;

  flags_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (flags_reg),
    .top   (stack_top),
    .count (occupancy),
    .err   (stack_err)
  );

  assign stack_full  = (occupancy == CW'(STACK_DEPTH));
  assign stack_empty = (occupancy == '0);
  // Covers both plain pop and swap; the stack writes the pre-update flags.
  assign stack_load  = pop && !stack_empty;
  assign res_ready   = !pop;
`else
  logic unused_stack_in;
  assign unused_stack_in = ^{push, pop, 5'(STACK_DEPTH)};
  assign stack_top   = '0;
  assign stack_err   = 1'b0;
  assign stack_load  = 1'b0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign res_ready   = 1'b1;
`endif

  assign op_class  = decode_op(res_op);
  assign op_ok     = (op_class != CLS_RSVD);
  assign accept    = res_valid && res_ready;
  assign alu_flags = compute_flags(op_class, res_value, res_carry, res_a_msb, res_b_msb);

  always_comb begin
    flags_next = flags_reg;
    if (stack_load) begin
      flags_next = stack_top;
    end else if (accept && op_ok) begin
      flags_next = merge_flags(flags_reg, alu_flags, update_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      if ((accept && !op_ok) || stack_err) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign current_flags = flags_reg;
  assign err_sticky    = err_reg;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: vector table, stack/reset sequences and
// randomized traffic against a behavioural model (follows FLAGS_UNIT_STACK_EN).
module tb_flags_unit;

  localparam int DEPTH = 4;
`ifdef FLAGS_UNIT_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_op;
  logic [31:0] res_value;
  logic        res_carry;
  logic        res_a_msb;
  logic        res_b_msb;
  logic [3:0]  update_mask;
  logic        push;
  logic        pop;
  logic [3:0]  current_flags;
  logic        stack_full;
  logic        stack_empty;
  logic        err_sticky;

  int tests = 0;
  int fails = 0;

  flags_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_op        (res_op),
    .res_value     (res_value),
    .res_carry     (res_carry),
    .res_a_msb     (res_a_msb),
    .res_b_msb     (res_b_msb),
    .update_mask   (update_mask),
    .push          (push),
    .pop           (pop),
    .current_flags (current_flags),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .err_sticky    (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  logic [3:0] m_flags;
  logic       m_err;
  logic [3:0] m_stack[$];

  // V: the operands (B negated for SUB) share a sign that the result lost.
  function automatic logic [3:0] spec_flags(input logic [2:0] op, input logic [31:0] val,
                                            input logic c, input logic a, input logic b);
    logic eff_b;
    logic v;
    eff_b = (op == 3'd1) ? !b : b;
    v = (op != 3'd2) && (a == eff_b) && (val[31] != a);
    return {val[31], val == 32'd0, c, v};
  endfunction

  function automatic void model_reset();
    m_flags = 4'b0000;
    m_err   = 1'b0;
    m_stack.delete();
  endfunction

  function automatic void model_step(input logic v, input logic [2:0] op, input logic [31:0] val,
                                     input logic c, input logic a, input logic b,
                                     input logic [3:0] m, input logic ps, input logic pp);
    logic [3:0] nf;
    logic [3:0] tmp;
    if (STACK_EN && pp) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else if (ps) begin
        tmp = m_stack[$];
        m_stack[$] = m_flags;
        m_flags = tmp;
      end else m_flags = m_stack.pop_back();
    end else begin
      nf = m_flags;
      if (STACK_EN && ps) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(m_flags);
      end
      if (v) begin
        if (op > 3'd2) m_err = 1'b1;
        else begin
          tmp = spec_flags(op, val, c, a, b);
          for (int i = 0; i < 4; i++) if (m[i]) nf[i] = tmp[i];
        end
      end
      m_flags = nf;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, ".flags"}, 32'(current_flags), 32'(m_flags));
    check({name, ".err"},   32'(err_sticky),    32'(m_err));
    check({name, ".full"},  32'(stack_full),    32'(m_stack.size() == DEPTH));
    check({name, ".empty"}, 32'(stack_empty),   32'(m_stack.size() == 0));
  endtask

  task automatic idle();
    res_valid = 1'b0; res_op = 3'd0; res_value = 32'd0; res_carry = 1'b0;
    res_a_msb = 1'b0; res_b_msb = 1'b0; update_mask = 4'd0; push = 1'b0; pop = 1'b0;
  endtask

  // One clock: drive, check ready before the edge, step the model, resume #1 after the edge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] val,
                       input logic c, input logic a, input logic b, input logic [3:0] m,
                       input logic ps, input logic pp);
    res_valid = v; res_op = op; res_value = val; res_carry = c;
    res_a_msb = a; res_b_msb = b; update_mask = m; push = ps; pop = pp;
    #1;
    check("ready", 32'(res_ready), 32'(STACK_EN ? !pp : 1'b1));
    model_step(v, op, val, c, a, b, m, ps, pp);
    @(posedge clk);
    #1;
    $display("[TB] t=%0t v=%0b op=%0d val=%h m=%b push=%0b pop=%0b -> flags=%b err=%0b full=%0b empty=%0b",
             $time, v, op, val, m, ps, pp, current_flags, err_sticky, stack_full, stack_empty);
    idle();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".flags"}, 32'(current_flags), 32'h0);
    check({name, ".err"},   32'(err_sticky),    32'h0);
    check({name, ".full"},  32'(stack_full),    32'h0);
    check({name, ".empty"}, 32'(stack_empty),   32'h1);
    check({name, ".ready"}, 32'(res_ready),     32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] value;
    logic        carry;
    logic        a_msb;
    logic        b_msb;
    logic [3:0]  mask;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  vec_t tbl[12];
  logic [31:0] push_val[DEPTH+1];
  logic        push_c[DEPTH+1];
  logic [3:0]  pop_exp[DEPTH];

  initial begin
    // Chained: each expectation assumes the flags left by the previous entry.
    tbl[0]  = '{"add_zero",    3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0110, 1'b0};
    tbl[1]  = '{"add_ovf",     3'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1001, 1'b0};
    tbl[2]  = '{"logic_z",     3'd2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b1101, 1'b0};
    tbl[3]  = '{"logic_cv",    3'd2, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0};
    tbl[4]  = '{"sub_ovf",     3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 4'b0011, 4'b1111, 1'b0};
    tbl[5]  = '{"logic_neg",   3'd2, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1010, 1'b0};
    tbl[6]  = '{"sub_nc",      3'd1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[7]  = '{"mask_none",   3'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{"sub_v_neg",   3'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b1001, 1'b0};
    tbl[9]  = '{"add_nov_neg", 3'd0, 32'h8000_0001, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1010, 1'b0};
    tbl[10] = '{"rsvd_111",    3'd7, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1010, 1'b1};
    tbl[11] = '{"rsvd_011",    3'd3, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010, 1'b1};

    // Push sequence: LOGIC updates give flags 0110,1010,0010,0100,1000 in turn.
    push_val = '{32'h0, 32'h8000_0000, 32'h1, 32'h0, 32'h8000_0000};
    push_c   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    pop_exp  = '{4'b0010, 4'b1010, 4'b0110, 4'b0000};

    idle();
    model_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_release");

    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].op, tbl[i].value, tbl[i].carry, tbl[i].a_msb, tbl[i].b_msb,
            tbl[i].mask, 1'b0, 1'b0);
      check({tbl[i].name, ".flags"}, 32'(current_flags), 32'(tbl[i].exp_flags));
      check({tbl[i].name, ".err"},   32'(err_sticky),    32'(tbl[i].exp_err));
    end

    // Push with a same-cycle update saves the old flags; pop blocks any result.
    do_reset();
    cycle(1'b1, 3'd2, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
    check("save.pre", 32'(current_flags), 32'h0000_000A);
    cycle(1'b1, 3'd2, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
    check("save.upd", 32'(current_flags), 32'h0);
    check("save.empty", 32'(stack_empty), 32'(!STACK_EN));
    cycle(1'b1, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    check("restore.flags", 32'(current_flags), STACK_EN ? 32'h0000_000A : 32'h0000_0006);
    check("restore.empty", 32'(stack_empty), 32'h1);
    check("restore.err", 32'(err_sticky), 32'h0);

    // Overfill then drain in LIFO order.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, 3'd2, push_val[i], push_c[i], 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
      check($sformatf("fill%0d.full", i), 32'(stack_full), 32'(STACK_EN && i >= DEPTH - 1));
      check($sformatf("fill%0d.err", i), 32'(err_sticky), 32'(STACK_EN && i == DEPTH));
    end
    check("fill.flags", 32'(current_flags), 32'h0000_0008);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      check($sformatf("drain%0d.flags", i), 32'(current_flags),
            STACK_EN ? 32'(pop_exp[i]) : 32'h0000_0008);
      check($sformatf("drain%0d.full", i), 32'(stack_full), 32'h0);
    end
    check("drain.empty", 32'(stack_empty), 32'h1);
    check("drain.err", 32'(err_sticky), 32'(STACK_EN));

    // Asynchronous reset asserted mid-cycle with a request in flight.
    do_reset();
    cycle(1'b1, 3'd7, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
    check("midop.flags_set", 32'(current_flags), 32'h0000_000A);
    check("midop.err_set", 32'(err_sticky), 32'h1);
    res_valid = 1'b1; res_op = 3'd0; res_value = 32'h8000_0000; update_mask = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_rst");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midop_release");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  op;
      logic [31:0] val;
      int          sel;
      sel = $urandom_range(0, 15);
      op  = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       val = 32'h0;
        1:       val = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: val = $urandom;
      endcase
      cycle(1'($urandom_range(0, 1)), op, val, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      check_model($sformatf("rnd%0d", n));
      if (n == 200) begin
        do_reset();
        check_model("rnd_reset");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
